// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive path: the transmit
// arbiter FSM state encoding and the frame-width / CTS synchronizer
// depth defaults used by the arbiter, serializer and receiver.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS   = 8;
   localparam int UART_SYNC_STAGES = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_t;

endpackage : uart_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin priority rotate. The search starts at
// index ptr and walks ptr+1, ptr+2, ... modulo N; the first asserted
// request wins.
//
// Ports:
//   req       in   N      request vector
//   ptr       in   IDX_W  highest-priority index (must be < N)
//   grant     out  N      one-hot grant (all zero when no request)
//   grant_idx out  IDX_W  encoded index of the granted request
//   any_req   out  1      at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any_req
);

   // Modulo-N rotate done in int arithmetic so a non-power-of-2 N can
   // never produce an index at or beyond N.
   function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] p,
                                                input int off);
      int sum;
      sum = int'(p) + off;
      if (sum >= N) begin
         sum = sum - N;
      end
      return IDX_W'(sum);
   endfunction

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      // Walk from the farthest offset back to ptr so that the closest
      // asserted request is the last assignment and therefore wins.
      for (int off = N - 1; off >= 0; off--) begin
         if (req[rot_idx(ptr, off)]) begin
            grant_idx = rot_idx(ptr, off);
         end
      end
      if (any_req) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART byte serializer between NUM_REQ requesters with
// round-robin priority, holds off new frames while the FTDI CTS# pin is
// deasserted, and runs the serializer's start/busy handshake with a
// watchdog on the busy acknowledge.
//
// Ports:
//   clk         in   1                  system clock
//   rst         in   1                  asynchronous active-high reset
//   req_valid   in   NUM_REQ            per-requester byte available
//   req_data    in   NUM_REQ*DATA_BITS  requester i at [i*DATA_BITS +: DATA_BITS]
//   req_ready   out  NUM_REQ            one-hot accept (transfer on valid&ready)
//   cts_n       in   1                  raw CTS#, active-low, asynchronous
//   tx_start    out  1                  one-cycle start pulse to serializer
//   tx_data     out  DATA_BITS          byte held for the serializer
//   tx_busy     in   1                  serializer busy for the whole frame
//   grant_id    out  clog2(NUM_REQ)     index of the last granted requester
//   err_timeout out  1                  sticky: serializer never went busy
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_BITS    = UART_DATA_BITS,
   parameter int SYNC_STAGES  = UART_SYNC_STAGES,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           cts_n,
   output logic                           tx_start,
   output logic [DATA_BITS-1:0]           tx_data,
   input  logic                           tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]     grant_id,
   output logic                           err_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   tx_state_t              state_reg, state_next;
   logic [IDX_W-1:0]       ptr_reg, ptr_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [DATA_BITS-1:0]   tx_data_reg, tx_data_next;
   logic [IDX_W-1:0]       grant_id_reg, grant_id_next;
   logic                   err_reg, err_next;
   logic [SYNC_STAGES-1:0] cts_sync_reg;

   logic                   clear_to_send;
   logic [NUM_REQ-1:0]     arb_grant;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_any;
   logic [IDX_W-1:0]       ptr_after;

   // CTS# synchronizer; resets to all ones so the link starts "not clear".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cts_sync_reg <= '1;
      end else begin
         cts_sync_reg <= {cts_sync_reg[SYNC_STAGES-2:0], cts_n};
      end
   end

   assign clear_to_send = ~cts_sync_reg[SYNC_STAGES-1];

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   // Priority moves to the requester after the one just served, so a
   // continuously valid requester waits at most NUM_REQ frames.
   assign ptr_after = (grant_id_reg == IDX_W'(NUM_REQ - 1)) ? '0
                                                           : grant_id_reg + IDX_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= '0;
         cnt_reg      <= '0;
         tx_data_reg  <= '0;
         grant_id_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ptr_reg      <= ptr_next;
         cnt_reg      <= cnt_next;
         tx_data_reg  <= tx_data_next;
         grant_id_reg <= grant_id_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      ptr_next      = ptr_reg;
      cnt_next      = cnt_reg;
      tx_data_next  = tx_data_reg;
      grant_id_next = grant_id_reg;
      err_next      = err_reg;
      req_ready     = '0;
      tx_start      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // CTS only gates the decision to begin a new frame.
            if (clear_to_send && arb_any) begin
               req_ready     = arb_grant;
               tx_data_next  = req_data[int'(arb_idx)*DATA_BITS +: DATA_BITS];
               grant_id_next = arb_idx;
               state_next    = ST_START;
            end
         end
         ST_START: begin
            tx_start   = 1'b1;
            cnt_next   = '0;
            state_next = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = ST_WAIT_DONE;
            end else if (cnt_reg == CNT_W'(BUSY_TIMEOUT - 1)) begin
               // Counter would reach BUSY_TIMEOUT on this edge: give up
               // and drop the byte.
               err_next   = 1'b1;
               ptr_next   = ptr_after;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               ptr_next   = ptr_after;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign tx_data     = tx_data_reg;
   assign grant_id    = grant_id_reg;
   assign err_timeout = err_reg;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int NUM_REQ      = 4;
   localparam int DATA_BITS    = 8;
   localparam int SYNC_STAGES  = 3;
   localparam int BUSY_TIMEOUT = 15;
   localparam int BUSY_LEN     = 10;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         cts_n;
   logic                         tx_start;
   logic [DATA_BITS-1:0]         tx_data;
   logic                         tx_busy;
   logic [1:0]                   grant_id;
   logic                         err_timeout;

   int total  = 0;
   int bad    = 0;
   int frames = 0;
   bit busy_en = 1'b1;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .DATA_BITS    (DATA_BITS),
      .SYNC_STAGES  (SYNC_STAGES),
      .BUSY_TIMEOUT (BUSY_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .cts_n       (cts_n),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .err_timeout (err_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      req_data[i*DATA_BITS +: DATA_BITS] = v;
   endtask

   task automatic push(input int id, input logic [7:0] d);
      exp_t e;
      e.id   = 2'(id);
      e.data = d;
      sb.push_back(e);
   endtask

   // Wait (bounded) for requester idx to be accepted, then drop its valid.
   task automatic wait_accept(input int idx);
      bit seen = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (req_ready[idx] === 1'b1) begin
            seen = 1'b1;
            check($sformatf("ready_onehot_req%0d", idx), req_ready, 32'(1) << idx);
            break;
         end
      end
      check($sformatf("accept_req%0d", idx), seen, 1);
      tick();
      req_valid[idx] = 1'b0;
   endtask

   // Serializer model and scoreboard consumer.
   initial begin
      exp_t e;
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            frames++;
            if (sb.size() == 0) begin
               check("sb_unexpected_start", 1, 0);
            end else begin
               e = sb.pop_front();
               check("sb_grant_id", grant_id, e.id);
               check("sb_tx_data", tx_data, e.data);
            end
            if (busy_en) begin
               @(posedge clk);
               #1 tx_busy = 1'b1;
               repeat (BUSY_LEN) @(posedge clk);
               #1 tx_busy = 1'b0;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int grants;
      int ready_k;
      int start_k;

      rst = 1'b1; cts_n = 1'b1; req_valid = '0; req_data = '0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_err", err_timeout, 0);
      tick();
      rst = 1'b0;

      // Single requester, then a new request held off while busy.
      cts_n = 1'b0;
      repeat (5) tick();
      set_data(2, 8'hA5); req_valid = 4'b0100; push(2, 8'hA5);
      @(negedge clk);
      check("t1_ready", req_ready, 4'b0100);
      tick();
      req_valid = 4'b0001; set_data(0, 8'h3C); push(0, 8'h3C);
      @(negedge clk);
      check("t1_tx_start", tx_start, 1);
      check("t1_ready_at_start", req_ready, 0);
      for (int k = 0; k < BUSY_LEN; k++) begin
         @(negedge clk);
         check("t1_ready_busy", req_ready, 0);
      end
      wait_accept(0);
      repeat (20) tick();

      // Round robin from a fresh pointer.
      rst = 1'b1; repeat (2) tick(); rst = 1'b0; repeat (5) tick();
      for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'h10 + i));
      push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
      req_valid = '1;
      grants = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (req_ready !== '0) begin
            grants++;
            if (grants == 5) begin
               tick();
               req_valid = '0;
               break;
            end
         end
      end
      check("t2_grants", grants, 5);
      repeat (20) tick();

      // Flow control: CTS deasserted blocks grants.
      cts_n = 1'b1;
      repeat (5) tick();
      set_data(0, 8'h5A); req_valid = 4'b0001;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         check("t3_ready_blocked", req_ready, 0);
         check("t3_start_blocked", tx_start, 0);
      end
      tick();
      cts_n = 1'b0; push(0, 8'h5A);
      ready_k = -1; start_k = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready[0] === 1'b1 && ready_k < 0) ready_k = k;
         if (tx_start === 1'b1) begin
            start_k = k;
            break;
         end
         tick();
         if (ready_k >= 0) req_valid[0] = 1'b0;
      end
      check("t3_ready_latency", ready_k, SYNC_STAGES);
      check("t3_start_latency", start_k, SYNC_STAGES + 1);
      tick(); tick();
      cts_n = 1'b1; set_data(1, 8'hC3); req_valid = 4'b0010;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         check("t3_midframe_ready", req_ready, 0);
         check("t3_midframe_start", tx_start, 0);
      end
      tick();
      cts_n = 1'b0; push(1, 8'hC3);
      wait_accept(1);
      repeat (20) tick();

      // Busy timeout.
      busy_en = 1'b0;
      set_data(2, 8'h77); req_valid = 4'b0100; push(2, 8'h77);
      wait_accept(2);
      @(negedge clk);
      check("t4_tx_start", tx_start, 1);
      for (int k = 1; k <= BUSY_TIMEOUT; k++) begin
         @(negedge clk);
         check("t4_err_early", err_timeout, 0);
      end
      @(negedge clk);
      check("t4_err_set", err_timeout, 1);
      tick();
      busy_en = 1'b1;
      set_data(3, 8'hE1); set_data(0, 8'hE0); req_valid = 4'b1001;
      push(3, 8'hE1); push(0, 8'hE0);
      wait_accept(3);
      wait_accept(0);
      repeat (20) tick();
      check("t4_err_sticky", err_timeout, 1);

      // Asynchronous reset in the middle of a frame.
      set_data(2, 8'h99); req_valid = 4'b0100; push(2, 8'h99);
      wait_accept(2);
      repeat (5) tick();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_tx_start", tx_start, 0);
      check("t5_rst_ready", req_ready, 0);
      check("t5_rst_grant_id", grant_id, 0);
      check("t5_rst_err", err_timeout, 0);
      check("t5_rst_tx_data", tx_data, 0);
      tick(); tick();
      rst = 1'b0;
      repeat (15) tick();
      set_data(0, 8'hB0); set_data(3, 8'hB3); req_valid = 4'b1001;
      push(0, 8'hB0); push(3, 8'hB3);
      wait_accept(0);
      wait_accept(3);
      repeat (20) tick();

      // Skipped requester: requester 1 withdraws before it can be granted.
      set_data(0, 8'h11); req_valid = 4'b0001; push(0, 8'h11);
      wait_accept(0);
      tick();
      set_data(0, 8'h22); set_data(1, 8'h33); req_valid = 4'b0011; push(0, 8'h22);
      repeat (3) tick();
      req_valid[1] = 1'b0;
      wait_accept(0);
      repeat (20) tick();
      set_data(1, 8'h44); set_data(0, 8'h55); req_valid = 4'b0011;
      push(1, 8'h44); push(0, 8'h55);
      wait_accept(1);
      wait_accept(0);
      repeat (20) tick();

      check("sb_drained", sb.size(), 0);
      check("frame_count", frames, 19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_tx_arbiter
